dmem_rw_unit_param: RTL and testbench

Parametrised successor to the single-entry dmem read/write unit. Sits between the load-store unit and the data memory port.
- Buffers up to DEPTH memory requests in order and issues them to dmem one at a time.
- Supports byte, half, word and (when DATA_W=64) dword accesses, with byte enables, load sign/zero extension and misalignment detection.
- Broadcasts load results on the CDB and holds each result until granted.

---
 rtl/dmem_rw_unit_param.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_dmem_rw_unit_param.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_rw_unit_param.sv
// dmem_rw_unit_param: in-order request FIFO in front of a single-outstanding
// dmem port. Handles sub-word store lane shifting and byte enables, load
// extraction with sign/zero extension, misalignment faults, and holding load
// results on the CDB until they are granted.
// Optional build macro DMEM_TIMEOUT_EN adds a watchdog on the dmem access.
module dmem_rw_unit_param #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                lsu_valid_i,
  output logic                lsu_ready_o,
  input  logic                lsu_load_i,
  input  logic [1:0]          lsu_size_i,
  input  logic                lsu_unsigned_i,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic [DATA_W-1:0]   lsu_st_data_i,
  input  logic [TAG_W-1:0]    lsu_tag_i,
  output logic                dmem_read_o,
  output logic                dmem_write_o,
  output logic [ADDR_W-1:0]   dmem_addr_o,
  output logic [DATA_W-1:0]   dmem_data_o,
  output logic [DATA_W/8-1:0] dmem_be_o,
  input  logic [DATA_W-1:0]   dmem_rd_data_i,
  input  logic                dmem_done_i,
  output logic                cdb_valid_o,
  output logic [TAG_W-1:0]    cdb_tag_o,
  output logic [DATA_W-1:0]   cdb_data_o,
  output logic                cdb_err_o,
  input  logic                cdb_grant_i,
  output logic                store_err_o,
  output logic                idle_o
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  typedef struct packed {
    logic              load;
    logic [1:0]        size;
    logic              uns;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } req_t;

  // Attributes of the access currently in flight, needed for load extraction.
  typedef struct packed {
    logic             load;
    logic [1:0]       size;
    logic             uns;
    logic [OFF_W-1:0] off;
    logic [TAG_W-1:0] tag;
  } cur_t;

  req_t             fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full_c, empty_c, push_c, pop_c;
  req_t             req_in_c, head_c;

  state_e            state_q, state_d;
  cur_t              cur_q, cur_d;
  logic              dmem_read_q, dmem_read_d, dmem_write_q, dmem_write_d;
  logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0] dmem_data_q, dmem_data_d;
  logic [BE_W-1:0]   dmem_be_q, dmem_be_d;
  logic              cdb_valid_q, cdb_valid_d, cdb_err_q, cdb_err_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic              store_err_q, store_err_d;

  logic              mis_c;
  logic [BE_W-1:0]   be_mask_c;
  logic [DATA_W-1:0] st_shift_c, ld_shift_c, ld_mask_c, ld_ext_c;
  logic              ld_sgn_c;

  assign full_c   = (count_q == CNT_W'(DEPTH));
  assign empty_c  = (count_q == '0);
  assign push_c   = lsu_valid_i && !full_c;
  assign req_in_c = '{load: lsu_load_i, size: lsu_size_i, uns: lsu_unsigned_i,
                      addr: lsu_addr_i, data: lsu_st_data_i, tag: lsu_tag_i};
  assign head_c   = fifo_q[rd_ptr_q];

  // FIFO storage; contents are don't-care while the slot is empty.
  always_ff @(posedge clk_i) begin
    if (push_c) fifo_q[wr_ptr_q] <= req_in_c;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Head request alignment check, store lane shift and byte enables.
  always_comb begin
    mis_c = 1'b0;
    be_mask_c = '1;
    case (head_c.size)
      2'd0: be_mask_c = BE_W'(1);
      2'd1: begin be_mask_c = BE_W'(3);  mis_c = head_c.addr[0]; end
      2'd2: begin be_mask_c = BE_W'(15); mis_c = (head_c.addr[1:0] != 2'b00); end
      default: begin
        be_mask_c = '1;
        mis_c     = (DATA_W == 32) || (head_c.addr[2:0] != 3'b000);
      end
    endcase
    st_shift_c = head_c.data << {head_c.addr[OFF_W-1:0], 3'b000};
  end

  // Load result extraction from the returned memory word.
  always_comb begin
    ld_shift_c = dmem_rd_data_i >> {cur_q.off, 3'b000};
    case (cur_q.size)
      2'd0:    begin ld_mask_c = DATA_W'(8'hFF);         ld_sgn_c = ld_shift_c[7];  end
      2'd1:    begin ld_mask_c = DATA_W'(16'hFFFF);      ld_sgn_c = ld_shift_c[15]; end
      2'd2:    begin ld_mask_c = DATA_W'(32'hFFFF_FFFF); ld_sgn_c = ld_shift_c[31]; end
      default: begin ld_mask_c = '1;                     ld_sgn_c = ld_shift_c[DATA_W-1]; end
    endcase
    ld_ext_c = (ld_shift_c & ld_mask_c) |
               ({DATA_W{ld_sgn_c && !cur_q.uns}} & ~ld_mask_c);
  end

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_hit_c;

  assign tmo_hit_c = (tmo_q == TMO_W'(TIMEOUT - 1));

  // Watchdog cycle counter for the outstanding dmem access.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) tmo_q <= '0;
    else           tmo_q <= tmo_d;
  end
`else
  logic unused_timeout_c;
  assign unused_timeout_c = ^32'(TIMEOUT);
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    dmem_read_d  = dmem_read_q;
    dmem_write_d = dmem_write_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_data_d  = dmem_data_q;
    dmem_be_d    = dmem_be_q;
    cdb_valid_d  = cdb_valid_q;
    cdb_tag_d    = cdb_tag_q;
    cdb_data_d   = cdb_data_q;
    cdb_err_d    = cdb_err_q;
    store_err_d  = 1'b0;
    pop_c        = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    tmo_d        = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (!empty_c) begin
          pop_c = 1'b1;
          cur_d = '{load: head_c.load, size: head_c.size, uns: head_c.uns,
                    off: head_c.addr[OFF_W-1:0], tag: head_c.tag};
          if (mis_c) begin
            if (head_c.load) begin
              cdb_valid_d = 1'b1;
              cdb_tag_d   = head_c.tag;
              cdb_data_d  = '0;
              cdb_err_d   = 1'b1;
              state_d     = RESP;
            end else begin
              store_err_d = 1'b1;
            end
          end else begin
            dmem_read_d  = head_c.load;
            dmem_write_d = !head_c.load;
            dmem_addr_d  = {head_c.addr[ADDR_W-1:OFF_W], OFF_W'(0)};
            dmem_data_d  = st_shift_c;
            dmem_be_d    = be_mask_c << head_c.addr[OFF_W-1:0];
            state_d      = BUSY;
`ifdef DMEM_TIMEOUT_EN
            tmo_d        = '0;
`endif
          end
        end
      end
      BUSY: begin
`ifdef DMEM_TIMEOUT_EN
        tmo_d = tmo_q + TMO_W'(1);
`endif
        if (dmem_done_i) begin
          dmem_read_d  = 1'b0;
          dmem_write_d = 1'b0;
          dmem_addr_d  = '0;
          dmem_data_d  = '0;
          dmem_be_d    = '0;
          if (cur_q.load) begin
            cdb_valid_d = 1'b1;
            cdb_tag_d   = cur_q.tag;
            cdb_data_d  = ld_ext_c;
            cdb_err_d   = 1'b0;
            state_d     = RESP;
          end else begin
            state_d = IDLE;
          end
        end
`ifdef DMEM_TIMEOUT_EN
        else if (tmo_hit_c) begin
          dmem_read_d  = 1'b0;
          dmem_write_d = 1'b0;
          dmem_addr_d  = '0;
          dmem_data_d  = '0;
          dmem_be_d    = '0;
          if (cur_q.load) begin
            cdb_valid_d = 1'b1;
            cdb_tag_d   = cur_q.tag;
            cdb_data_d  = '0;
            cdb_err_d   = 1'b1;
            state_d     = RESP;
          end else begin
            store_err_d = 1'b1;
            state_d     = IDLE;
          end
        end
`endif
      end
      RESP: begin
        if (cdb_grant_i) begin
          cdb_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      cur_q        <= '0;
      dmem_read_q  <= 1'b0;
      dmem_write_q <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_data_q  <= '0;
      dmem_be_q    <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_tag_q    <= '0;
      cdb_data_q   <= '0;
      cdb_err_q    <= 1'b0;
      store_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      dmem_read_q  <= dmem_read_d;
      dmem_write_q <= dmem_write_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_data_q  <= dmem_data_d;
      dmem_be_q    <= dmem_be_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_tag_q    <= cdb_tag_d;
      cdb_data_q   <= cdb_data_d;
      cdb_err_q    <= cdb_err_d;
      store_err_q  <= store_err_d;
    end
  end

  assign lsu_ready_o  = !full_c;
  assign idle_o       = empty_c && (state_q == IDLE);
  assign dmem_read_o  = dmem_read_q;
  assign dmem_write_o = dmem_write_q;
  assign dmem_addr_o  = dmem_addr_q;
  assign dmem_data_o  = dmem_data_q;
  assign dmem_be_o    = dmem_be_q;
  assign cdb_valid_o  = cdb_valid_q;
  assign cdb_tag_o    = cdb_tag_q;
  assign cdb_data_o   = cdb_data_q;
  assign cdb_err_o    = cdb_err_q;
  assign store_err_o  = store_err_q;

endmodule

// File: tb/tb_dmem_rw_unit_param.sv
// Scoreboard bench for dmem_rw_unit_param (DATA_W=32, DEPTH=4, TIMEOUT=8).
// Stimulus pushes expected dmem accesses / CDB results / store faults into one
// in-order queue; a monitor pops and compares as the DUT presents them.
module tb_dmem_rw_unit_param;

  localparam int EV_ACC = 0, EV_CDB = 1, EV_SERR = 2;

  typedef struct {
    int          kind;
    logic        rd, wr;
    logic [31:0] addr, data;
    logic [3:0]  be, tag;
    logic [31:0] cdata;
    logic        err;
  } exp_t;

  typedef struct {
    int          lat;
    logic [31:0] rdata;
  } resp_t;

  logic clk, rst_n;
  logic lsu_valid, lsu_ready, lsu_load, lsu_uns;
  logic [1:0] lsu_size;
  logic [31:0] lsu_addr, lsu_st_data;
  logic [3:0] lsu_tag;
  logic dmem_read, dmem_write, dmem_done;
  logic [31:0] dmem_addr, dmem_data, dmem_rd_data;
  logic [3:0] dmem_be;
  logic cdb_valid, cdb_err, cdb_grant, store_err, idle;
  logic [3:0] cdb_tag;
  logic [31:0] cdb_data;

  int checks = 0, errors = 0;
  int grant_dly = 3;
  exp_t  exp_q[$];
  resp_t resp_q[$];

  dmem_rw_unit_param #(.ADDR_W(32), .DATA_W(32), .TAG_W(4), .DEPTH(4), .TIMEOUT(8)) dut (
    .clk_i(clk), .reset_ni(rst_n),
    .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready), .lsu_load_i(lsu_load),
    .lsu_size_i(lsu_size), .lsu_unsigned_i(lsu_uns), .lsu_addr_i(lsu_addr),
    .lsu_st_data_i(lsu_st_data), .lsu_tag_i(lsu_tag),
    .dmem_read_o(dmem_read), .dmem_write_o(dmem_write), .dmem_addr_o(dmem_addr),
    .dmem_data_o(dmem_data), .dmem_be_o(dmem_be), .dmem_rd_data_i(dmem_rd_data),
    .dmem_done_i(dmem_done),
    .cdb_valid_o(cdb_valid), .cdb_tag_o(cdb_tag), .cdb_data_o(cdb_data),
    .cdb_err_o(cdb_err), .cdb_grant_i(cdb_grant),
    .store_err_o(store_err), .idle_o(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_acc(input logic rd, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be);
    exp_t e;
    e = '{kind: EV_ACC, rd: rd, wr: !rd, addr: a, data: d, be: be,
          tag: 4'd0, cdata: 32'd0, err: 1'b0};
    exp_q.push_back(e);
  endtask

  task automatic exp_cdb(input logic [3:0] tg, input logic [31:0] cd, input logic er);
    exp_t e;
    e = '{kind: EV_CDB, rd: 1'b0, wr: 1'b0, addr: 32'd0, data: 32'd0, be: 4'd0,
          tag: tg, cdata: cd, err: er};
    exp_q.push_back(e);
  endtask

  task automatic exp_serr();
    exp_t e;
    e = '{kind: EV_SERR, rd: 1'b0, wr: 1'b0, addr: 32'd0, data: 32'd0, be: 4'd0,
          tag: 4'd0, cdata: 32'd0, err: 1'b0};
    exp_q.push_back(e);
  endtask

  task automatic resp(input int lat, input logic [31:0] rd);
    resp_t r;
    r.lat = lat;
    r.rdata = rd;
    resp_q.push_back(r);
  endtask

  // Present one request and hold it until accepted.
  task automatic enq(input logic ld, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] d, input logic [3:0] tg);
    bit ok;
    ok = 1'b0;
    lsu_load = ld; lsu_size = sz; lsu_uns = uns;
    lsu_addr = a; lsu_st_data = d; lsu_tag = tg; lsu_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (lsu_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("enq_ready_timeout", 0, 1);
    @(posedge clk); #1;
    lsu_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (idle && exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    chk(name, 64'(ok), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Memory responder: completes each access after its scripted latency.
  initial begin
    resp_t r;
    dmem_done = 1'b0;
    dmem_rd_data = '0;
    forever begin
      @(negedge clk);
      if (rst_n && (dmem_read || dmem_write)) begin
        if (resp_q.size() != 0) r = resp_q.pop_front();
        else begin r.lat = 1; r.rdata = '0; end
        if (r.lat < 0) begin
          for (int i = 0; i < 2000; i++) begin
            if (!(dmem_read || dmem_write)) break;
            @(negedge clk);
          end
        end else begin
          repeat (r.lat) @(posedge clk);
          #1;
          dmem_done = 1'b1;
          dmem_rd_data = r.rdata;
          @(posedge clk); #1;
          dmem_done = 1'b0;
          dmem_rd_data = '0;
        end
      end
    end
  end

  // CDB granter: accepts each result grant_dly cycles after it appears.
  initial begin
    cdb_grant = 1'b0;
    forever begin
      @(negedge clk);
      if (cdb_valid) begin
        repeat (grant_dly - 1) @(posedge clk);
        #1 cdb_grant = 1'b1;
        @(posedge clk); #1;
        cdb_grant = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every new event and checks held values.
  initial begin
    exp_t ca, cc, cs;
    bit acc_prev, cdb_prev, acc_ok, cdb_ok;
    int held;
    acc_prev = 0; cdb_prev = 0; acc_ok = 0; cdb_ok = 0; held = 0;
    forever begin
      @(negedge clk);
      if (dmem_read || dmem_write) begin
        if (!acc_prev) begin
          acc_ok = 0;
          if (exp_q.size() == 0) chk("unexpected_access", 1, 0);
          else begin
            ca = exp_q.pop_front();
            if (ca.kind != EV_ACC) chk("event_order_acc", 64'(ca.kind), 64'(EV_ACC));
            else acc_ok = 1;
          end
        end
        if (acc_ok) begin
          chk("dmem_read", 64'(dmem_read), 64'(ca.rd));
          chk("dmem_write", 64'(dmem_write), 64'(ca.wr));
          chk("dmem_addr", 64'(dmem_addr), 64'(ca.addr));
          chk("dmem_data", 64'(dmem_data), 64'(ca.data));
          chk("dmem_be", 64'(dmem_be), 64'(ca.be));
        end
      end else if (acc_prev) begin
        chk("dmem_addr_cleared", 64'(dmem_addr), 0);
        chk("dmem_data_cleared", 64'(dmem_data), 0);
        chk("dmem_be_cleared", 64'(dmem_be), 0);
      end
      acc_prev = dmem_read || dmem_write;

      if (cdb_valid) begin
        if (!cdb_prev) begin
          cdb_ok = 0;
          held = 0;
          if (exp_q.size() == 0) chk("unexpected_cdb", 1, 0);
          else begin
            cc = exp_q.pop_front();
            if (cc.kind != EV_CDB) chk("event_order_cdb", 64'(cc.kind), 64'(EV_CDB));
            else cdb_ok = 1;
          end
        end
        held++;
        if (cdb_ok) begin
          chk("cdb_tag", 64'(cdb_tag), 64'(cc.tag));
          chk("cdb_data", 64'(cdb_data), 64'(cc.cdata));
          chk("cdb_err", 64'(cdb_err), 64'(cc.err));
        end
      end else if (cdb_prev && rst_n) begin
        chk("cdb_hold_cycles", 64'(held), 64'(grant_dly));
      end
      cdb_prev = cdb_valid;

      if (store_err) begin
        if (exp_q.size() == 0) chk("unexpected_store_err", 1, 0);
        else begin
          cs = exp_q.pop_front();
          chk("event_order_serr", 64'(cs.kind), 64'(EV_SERR));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    lsu_valid = 1'b0; lsu_load = 1'b0; lsu_size = 2'd0; lsu_uns = 1'b0;
    lsu_addr = '0; lsu_st_data = '0; lsu_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dmem_read", 64'(dmem_read), 0);
    chk("rst_dmem_write", 64'(dmem_write), 0);
    chk("rst_cdb_valid", 64'(cdb_valid), 0);
    chk("rst_store_err", 64'(store_err), 0);
    chk("rst_ready", 64'(lsu_ready), 1);
    chk("rst_idle", 64'(idle), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Store word, done after 5 cycles.
    resp(5, 32'h0);
    exp_acc(1'b0, 32'h8, 32'hDEADBEEF, 4'b1111);
    enq(1'b0, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF, 4'd0);
    wait_idle("idle_after_store_word");

    // Byte loads signed/unsigned, then signed half from the upper lane.
    resp(2, 32'h000080FF);
    exp_acc(1'b1, 32'h4, 32'h0, 4'b0001);
    exp_cdb(4'd3, 32'hFFFFFFFF, 1'b0);
    enq(1'b1, 2'd0, 1'b0, 32'h4, 32'h0, 4'd3);
    resp(1, 32'h000080FF);
    exp_acc(1'b1, 32'h4, 32'h0, 4'b0001);
    exp_cdb(4'd3, 32'h000000FF, 1'b0);
    enq(1'b1, 2'd0, 1'b1, 32'h4, 32'h0, 4'd3);
    resp(3, 32'h80FF0000);
    exp_acc(1'b1, 32'h4, 32'h0, 4'b1100);
    exp_cdb(4'd3, 32'hFFFF80FF, 1'b0);
    enq(1'b1, 2'd1, 1'b0, 32'h6, 32'h0, 4'd3);
    wait_idle("idle_after_loads");

    // Store byte to the top lane.
    resp(1, 32'h0);
    exp_acc(1'b0, 32'h0, 32'hAB000000, 4'b1000);
    enq(1'b0, 2'd0, 1'b0, 32'h3, 32'h000000AB, 4'd0);
    wait_idle("idle_after_store_byte");

    // Five back-to-back requests while the first access is held off.
    resp(10, 32'h0); resp(2, 32'h0); resp(2, 32'h0); resp(2, 32'h0);
    resp(1, 32'h12345678);
    for (int i = 0; i < 4; i++)
      exp_acc(1'b0, 32'h10 + 32'(4 * i), 32'h11111111 * 32'(i + 1), 4'b1111);
    exp_acc(1'b1, 32'h20, 32'h0, 4'b1111);
    exp_cdb(4'd7, 32'h12345678, 1'b0);
    for (int i = 0; i < 4; i++)
      enq(1'b0, 2'd2, 1'b0, 32'h10 + 32'(4 * i), 32'h11111111 * 32'(i + 1), 4'd0);
    enq(1'b1, 2'd2, 1'b0, 32'h20, 32'h0, 4'd7);
    chk("ready_when_full", 64'(lsu_ready), 0);
    wait_idle("idle_after_burst");
    chk("idle_end_burst", 64'(idle), 1);

    // Misaligned word load and half store.
    exp_cdb(4'd5, 32'h0, 1'b1);
    enq(1'b1, 2'd2, 1'b0, 32'h2, 32'h0, 4'd5);
    wait_idle("idle_after_mis_load");
    exp_serr();
    enq(1'b0, 2'd1, 1'b0, 32'h1, 32'h1234, 4'd0);
    wait_idle("idle_after_mis_store");

    // Reset while BUSY with two requests queued.
    resp(-1, 32'h0);
    exp_acc(1'b1, 32'h30, 32'h0, 4'b1111);
    enq(1'b1, 2'd2, 1'b0, 32'h30, 32'h0, 4'd2);
    enq(1'b0, 2'd2, 1'b0, 32'h34, 32'h5, 4'd0);
    enq(1'b0, 2'd2, 1'b0, 32'h38, 32'h6, 4'd0);
    chk("busy_before_reset", 64'(dmem_read), 1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    resp_q.delete();
    chk("rstmid_dmem_read", 64'(dmem_read), 0);
    chk("rstmid_dmem_addr", 64'(dmem_addr), 0);
    chk("rstmid_dmem_be", 64'(dmem_be), 0);
    chk("rstmid_cdb_valid", 64'(cdb_valid), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_ready", 64'(lsu_ready), 1);
    chk("post_reset_idle", 64'(idle), 1);
    repeat (5) @(posedge clk);
    #1;
    resp(1, 32'h0);
    exp_acc(1'b0, 32'h44, 32'h0BADF00D, 4'b1111);
    enq(1'b0, 2'd2, 1'b0, 32'h44, 32'h0BADF00D, 4'd0);
    wait_idle("idle_after_resume");

`ifdef DMEM_TIMEOUT_EN
    // Load with no done: watchdog faults it after 8 BUSY cycles.
    begin
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      resp(-1, 32'h0);
      exp_acc(1'b1, 32'h40, 32'h0, 4'b1111);
      exp_cdb(4'd9, 32'h0, 1'b1);
      enq(1'b1, 2'd2, 1'b0, 32'h40, 32'h0, 4'd9);
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (dmem_read) n++;
        if (cdb_valid) begin seen = 1'b1; break; end
      end
      chk("timeout_cdb_seen", 64'(seen), 1);
      chk("timeout_busy_cycles", 64'(n), 8);
      wait_idle("idle_after_timeout");
    end
`endif

    chk("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
